// File: rtl/serial_sub_pkg.sv
// Shared ALU definitions for the digit-serial subtractor.
//   state_t     : FSM encoding (IDLE=0, BUSY=1, DONE=2)
//   DEF_WIDTH   : default operand width
//   DEF_DIGIT_W : default bits processed per BUSY cycle
//   num_digits  : digits per operation (WIDTH / DIGIT_W)
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_DIGIT_W = 4;

  function automatic int unsigned num_digits(input int unsigned width,
                                             input int unsigned digit_w);
    return width / digit_w;
  endfunction

endpackage

// File: rtl/serial_sub_sub_digit.sv
// Combinational DIGIT_W-bit subtract slice: {cout, d} = a_dig + ~b_dig + cin.
//   a_dig : minuend digit
//   b_dig : subtrahend digit
//   cin   : incoming carry (1 = no borrow)
//   d     : difference digit
//   cout  : outgoing carry (0 = borrow)
module sub_digit
  import serial_sub_pkg::*;
#(
  parameter int unsigned DIGIT_W = DEF_DIGIT_W
) (
  input  logic [DIGIT_W-1:0] a_dig,
  input  logic [DIGIT_W-1:0] b_dig,
  input  logic               cin,
  output logic [DIGIT_W-1:0] d,
  output logic               cout
);

  assign {cout, d} = {1'b0, a_dig} + {1'b0, ~b_dig} + {{DIGIT_W{1'b0}}, cin};

endmodule

// File: rtl/serial_sub.sv
// Digit-serial WIDTH-bit subtractor, diff = a - b, DIGIT_W bits per cycle,
// ripple carry held in a flop between digits. Valid/ready on both sides.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (a, b)
//   out_valid/out_ready : result handshake (diff, borrow, overflow, zero)
//   borrow   : unsigned a < b
//   overflow : signed overflow of a - b
//   zero     : diff == 0
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DIGIT_W = DEF_DIGIT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N     = num_digits(WIDTH, DIGIT_W);
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  if ((WIDTH % DIGIT_W) != 0) begin : g_bad_width
    $error("serial_sub: WIDTH must be a multiple of DIGIT_W");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_a_msb;
  logic               r_b_msb;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic               r_overflow;
  logic               r_zero;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [DIGIT_W-1:0] w_d;
  logic               w_c;
  logic [WIDTH-1:0]   w_diff_next;

  sub_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .a_dig (r_a[DIGIT_W-1:0]),
    .b_dig (r_b[DIGIT_W-1:0]),
    .cin   (r_carry),
    .d     (w_d),
    .cout  (w_c)
  );

  // New digit enters at the MSB end; after N shifts diff is fully aligned.
  assign w_diff_next = WIDTH'({w_d, r_diff} >> DIGIT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_cnt       <= '0;
      r_carry     <= 1'b1;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_a_msb    <= a[WIDTH-1];
            r_b_msb    <= b[WIDTH-1];
            r_cnt      <= '0;
            r_carry    <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_diff  <= w_diff_next;
          r_carry <= w_c;
          r_a     <= r_a >> DIGIT_W;
          r_b     <= r_b >> DIGIT_W;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_DIGIT) begin
            // Flags use the final digit's carry and the completed diff directly.
            r_borrow    <= ~w_c;
            r_overflow  <= (r_a_msb != r_b_msb) && (w_diff_next[WIDTH-1] != r_a_msb);
            r_zero      <= (w_diff_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

  localparam int W  = 32;
  localparam int DW = 4;
  localparam int N  = W / DW;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;
    logic         zero;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;
  logic         zero;
  res_t         obs;

  res_t sb[$];
  int   errors = 0;
  int   checks = 0;

  serial_sub #(.WIDTH(W), .DIGIT_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  assign obs = '{diff: diff, borrow: borrow, overflow: overflow, zero: zero};

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] t;
    res_t       r;
    t          = {1'b0, x} - {1'b0, y};
    r.diff     = t[W-1:0];
    r.borrow   = t[W];
    r.overflow = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
    r.zero     = (t[W-1:0] == '0);
    return r;
  endfunction

  // Presents operands, completes the accept edge, then scrambles the inputs.
  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: in_ready=%b required=1", in_ready);
    end
    @(posedge clk);
    sb.push_back(model(x, y));
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  // Counts cycles after the accept edge until out_valid (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 4 * N) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string name);
    int   lat;
    res_t exp;
    accept(x, y);
    wait_result(lat);
    checks++;
    if (lat != N) begin
      errors++;
      $display("FAIL %s_latency: got=%0d required=%0d", name, lat, N);
    end
    if (out_valid === 1'b1) begin
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s_result: diff=%h b=%b o=%b z=%b required diff=%h b=%b o=%b z=%b",
                 name, obs.diff, obs.borrow, obs.overflow, obs.zero,
                 exp.diff, exp.borrow, exp.overflow, exp.zero);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
      end
    end else begin
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, diff, borrow, overflow, zero} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%h flags=%b%b%b required 1 0 0 000",
               in_ready, out_valid, diff, borrow, overflow, zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(32'd5, 32'd3, "a5_b3");
    run_op(32'd3, 32'd5, "a3_b5");
  endtask

  task automatic test_boundaries();
    run_op(32'h8000_0000, 32'h0000_0001, "ovf_neg");
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, "ovf_pos");
    run_op(32'h1234_5678, 32'h1234_5678, "equal");
    run_op(32'hDEAD_BEEF, 32'h0000_0000, "b_zero");
    run_op(32'h0000_0000, 32'h0000_0001, "zero_minus_one");
  endtask

  task automatic test_backpressure();
    int   lat;
    res_t exp;
    out_ready = 1'b0;
    accept(32'h0001_0000, 32'h0000_0001);
    wait_result(lat);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b required=1", out_valid);
      void'(sb.pop_front());
    end else begin
      exp = sb[0];
      for (int i = 0; i < 5; i++) begin
        a = $urandom; b = $urandom; in_valid = i[0];
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== exp) begin
          errors++;
          $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b diff=%h required 0 1 %h",
                   i, in_ready, out_valid, obs.diff, exp.diff);
        end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      void'(sb.pop_front());
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      // in_valid pulses during DONE must not have started an operation.
      repeat (N + 2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_no_ghost: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    accept(32'hFFFF_0000, 32'h0000_1234);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    checks++;
    if ({in_ready, out_valid, diff, borrow, overflow, zero} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL midreset_state: in_ready=%b out_valid=%b diff=%h flags=%b%b%b required 1 0 0 000",
               in_ready, out_valid, diff, borrow, overflow, zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_discard: out_valid=%b required=0", out_valid);
    end
    run_op(32'd10, 32'd4, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: left=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
